alu_pm: RTL and testbench
=========================

// Module: alu_pm
// PURPOSE
//  Parametrised, power-managed ALU for the switchable PD_ALU domain. Provides single-cycle
//  logic/arith ops plus multi-cycle MUL/DIV/REM behind a start/ready handshake. Contains its
//  own power-sequencing FSM covering save, isolate, off and restore. Result retention and
//  output clamping are handled inside the block, so the always-on consumer (aon_block) sees
//  only clean or clamped values.
// PARAMETERS
//  WIDTH    16  operand/result width; must be >=4 and a power of 2
//  MUL_LAT  4   cycles from accepted MUL start to result_valid; must be >=2
//  ISO_VAL  0   WIDTH-bit value driven on result while isolated
// PORTS
//  clk           in   1      single clock; all logic on rising edge
//  rst           in   1      synchronous, active-high reset
//  A             in   WIDTH  operand A, sampled on accept
//  B             in   WIDTH  operand B, sampled on accept
//  opcode        in   4      operation select, sampled on accept
//  start         in   1      request; accepted when start && ready
//  ready         out  1      = (pstate==P_ON) && exec idle && !pwr_req
//  busy          out  1      multi-cycle op in flight
//  result        out  WIDTH  registered result; ISO_VAL while iso_active
//  result_valid  out  1      1-cycle pulse with new result; forced 0 while isolated
//  err           out  1      qualifies result_valid: divide-by-zero or illegal opcode
//  pwr_req       in   1      1 = request power-down; 0 = request power-up
//  pwr_ack       out  1      1 only in P_OFF
//  iso_active    out  1      1 in P_ISO, P_OFF and P_RESTORE
// BEHAVIOUR
//  Reset: pstate=P_ON, exec=IDLE; result, retention reg and operand regs =0;
//   result_valid=busy=err=pwr_ack=iso_active=0.
//  Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRA (arithmetic),
//   8 MUL (low WIDTH bits), 9 DIVU quotient, A REMU remainder, B-F illegal.
//   ADD/SUB wrap modulo 2^WIDTH. Shift amount = B[log2(WIDTH)-1:0].
//  Latency, accept at cycle T:
//   - ops 0-7 and illegal: result_valid at T+1.
//   - MUL: result_valid at T+MUL_LAT.
//   - DIV/REM: result_valid at T+WIDTH+1.
//  Illegal opcode: result=0, err=1, 1-cycle latency.
//  B==0 on DIV/REM: 1-cycle latency; DIV gives result=all-ones, REM gives result=A; err=1.
//  Exec FSM: IDLE -> MUL_EXEC / DIV_EXEC on accept -> IDLE on the cycle result_valid pulses.
//   busy=1 in MUL_EXEC/DIV_EXEC. start is ignored while !ready.
//   Back-to-back ops are allowed: start may be accepted in the same cycle result_valid pulses
//   if ready=1.
//  result holds its value between valid pulses.
//  Power FSM (ready=0 outside P_ON):
//   - P_ON -> P_SAVE when pwr_req && !busy. An in-flight op completes and pulses valid first.
//   - P_SAVE (1 cycle): retention reg <= result.
//   - P_SAVE -> P_ISO (1 cycle) -> P_OFF.
//   - P_OFF: pwr_ack=1; result, operand regs and exec FSM cleared, modelling state loss.
//   - P_OFF -> P_RESTORE when !pwr_req. P_RESTORE (1 cycle): result <= retention reg.
//   - P_RESTORE -> P_ON; iso_active drops on entering P_ON.
//  pwr_req dropped in P_SAVE/P_ISO: the sequence still completes to P_OFF, then restores.
//  start and pwr_req together in P_ON idle: pwr_req wins; start is not accepted.
//  rst at any time, including mid-op or in P_OFF: immediate return to reset state; any pending
//   result is discarded and no valid pulse is produced.
// STRUCTURE
//  alu_pkg holds:
//   - opcode localparams (OP_ADD..OP_REMU)
//   - power-state encodings P_ON/P_SAVE/P_ISO/P_OFF/P_RESTORE
//   - exec-state encodings IDLE/MUL_EXEC/DIV_EXEC
//  Sub-module alu_divider: iterative restoring unsigned divider, WIDTH cycles.
//   Ports clk, rst, go, dividend, divisor, quotient, remainder, done.
//  MUL: operands registered, product pipelined/delayed to meet MUL_LAT.
// TESTING (WIDTH=16, MUL_LAT=4)
//  1. ADD A=FFFF,B=0002 at T -> valid at T+1, result=0001, err=0; SRA A=8000,B=3 -> E000.
//  2. MUL A=0100,B=0100 at T -> busy T+1..T+3, valid at T+4, result=0000;
//     DIVU A=0064,B=0007 at T -> valid at T+17, result=000E; REMU same operands -> 0002.
//  3. DIVU A=1234,B=0 -> valid at T+1, result=FFFF, err=1; opcode C -> result=0000, err=1.
//  4. ADD gives result=00AA; pwr_req=1 -> SAVE, ISO, OFF; while OFF result=ISO_VAL,
//     pwr_ack=1, ready=0, start ignored; pwr_req=0 -> after RESTORE result=00AA, ready=1.
//  5. pwr_req=1 mid-DIV -> DIV completes with valid pulse before P_SAVE;
//     start+pwr_req in the same idle cycle -> no accept.
//  6. rst at cycle 5 of a DIV -> next cycle all outputs at reset values; no valid pulse;
//     rst in P_OFF -> P_ON, result=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the power-managed ALU: opcodes plus power and
// execution state encodings.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_NOR  = 4'h5;
   localparam logic [3:0] OP_SLL  = 4'h6;
   localparam logic [3:0] OP_SRA  = 4'h7;
   localparam logic [3:0] OP_MUL  = 4'h8;
   localparam logic [3:0] OP_DIVU = 4'h9;
   localparam logic [3:0] OP_REMU = 4'hA;

   typedef enum logic [2:0] {P_ON, P_SAVE, P_ISO, P_OFF, P_RESTORE} pstate_t;
   typedef enum logic [1:0] {IDLE, MUL_EXEC, DIV_EXEC} exec_t;

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring unsigned divider. The first quotient bit is resolved
// on the go edge, so quotient/remainder are final when done pulses WIDTH cycles later.
module alu_divider #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             done
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0]   dvs;
   logic [CW-1:0]      cnt;
   logic               running;
   logic [2*WIDTH-1:0] nxt;

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                    input logic [WIDTH-1:0] q,
                                                    input logic [WIDTH-1:0] d);
      logic [WIDTH:0] t;
      logic [WIDTH:0] diff;
      t    = {r, q[WIDTH-1]};
      diff = t - {1'b0, d};
      if (!diff[WIDTH])
         return {diff[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
      else
         return {t[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
   endfunction

   always_comb begin
      nxt = '0;
      if (go)
         nxt = div_step('0, dividend, divisor);
      else
         nxt = div_step(remainder, quotient, dvs);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         quotient  <= '0;
         remainder <= '0;
         dvs       <= '0;
         cnt       <= '0;
         running   <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (go) begin
            {remainder, quotient} <= nxt;
            dvs     <= divisor;
            cnt     <= CW'(WIDTH - 1);
            running <= 1'b1;
         end else if (running) begin
            {remainder, quotient} <= nxt;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
               running <= 1'b0;
               done    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/alu_pm.sv
// Power-managed ALU: single-cycle logic/arith ops, multi-cycle MUL/DIV/REM,
// and a save/isolate/off/restore sequencer with result retention and output clamping.
module alu_pm
   import alu_pkg::*;
#(
   parameter int               WIDTH   = 16,
   parameter int               MUL_LAT = 4,
   parameter logic [WIDTH-1:0] ISO_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       opcode,
   input  logic             start,
   output logic             ready,
   output logic             busy,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic             err,
   input  logic             pwr_req,
   output logic             pwr_ack,
   output logic             iso_active
);

   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = $clog2(MUL_LAT) + 1;

   pstate_t          pstate;
   exec_t            exec;
   logic [WIDTH-1:0] result_q, ret_q, op_a, op_b, mul_lo;
   logic [3:0]       op_q;
   logic [CW-1:0]    mul_cnt;
   logic             valid_q, err_q, iso_q, ack_q;
   logic             accept, is_div, div_go, div_rst, div_done;
   logic [WIDTH-1:0] div_quo, div_rem;

   function automatic logic [WIDTH-1:0] alu_simple(input logic [3:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
      logic [SHW-1:0] sh;
      sh = b[SHW-1:0];
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_NOR:  return ~(a | b);
         OP_SLL:  return a << sh;
         OP_SRA:  return $unsigned($signed(a) >>> sh);
         default: return '0;
      endcase
   endfunction

   assign ready        = (pstate == P_ON) && (exec == IDLE) && !pwr_req;
   assign busy         = (exec != IDLE);
   assign accept       = start && ready;
   assign is_div       = (opcode == OP_DIVU) || (opcode == OP_REMU);
   assign div_go       = accept && is_div && (B != '0);
   assign div_rst      = rst || (pstate == P_OFF);
   assign mul_lo       = op_a * op_b;
   assign result       = iso_q ? ISO_VAL : result_q;
   assign result_valid = valid_q && !iso_q;
   assign err          = err_q;
   assign pwr_ack      = ack_q;
   assign iso_active   = iso_q;

   alu_divider #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .rst       (div_rst),
      .go        (div_go),
      .dividend  (A),
      .divisor   (B),
      .quotient  (div_quo),
      .remainder (div_rem),
      .done      (div_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pstate   <= P_ON;
         exec     <= IDLE;
         result_q <= '0;
         ret_q    <= '0;
         op_a     <= '0;
         op_b     <= '0;
         op_q     <= '0;
         mul_cnt  <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         iso_q    <= 1'b0;
         ack_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;

         // Execution only runs in P_ON; ready already excludes other states.
         if (pstate == P_ON) begin
            case (exec)
               IDLE: begin
                  if (accept) begin
                     op_a <= A;
                     op_b <= B;
                     op_q <= opcode;
                     if (opcode == OP_MUL) begin
                        exec    <= MUL_EXEC;
                        mul_cnt <= CW'(MUL_LAT - 2);
                     end else if (is_div && B == '0) begin
                        result_q <= (opcode == OP_DIVU) ? '1 : A;
                        err_q    <= 1'b1;
                        valid_q  <= 1'b1;
                     end else if (is_div) begin
                        exec <= DIV_EXEC;
                     end else if (opcode > OP_REMU) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                        valid_q  <= 1'b1;
                     end else begin
                        result_q <= alu_simple(opcode, A, B);
                        valid_q  <= 1'b1;
                     end
                  end
               end
               MUL_EXEC: begin
                  if (mul_cnt == '0) begin
                     result_q <= mul_lo;
                     valid_q  <= 1'b1;
                     exec     <= IDLE;
                  end else begin
                     mul_cnt <= mul_cnt - CW'(1);
                  end
               end
               DIV_EXEC: begin
                  if (div_done) begin
                     result_q <= (op_q == OP_REMU) ? div_rem : div_quo;
                     valid_q  <= 1'b1;
                     exec     <= IDLE;
                  end
               end
               default: exec <= IDLE;
            endcase
         end

         case (pstate)
            P_ON: begin
               if (pwr_req && exec == IDLE)
                  pstate <= P_SAVE;
            end
            P_SAVE: begin
               ret_q  <= result_q;
               iso_q  <= 1'b1;
               pstate <= P_ISO;
            end
            P_ISO: begin
               ack_q  <= 1'b1;
               pstate <= P_OFF;
            end
            // Off models loss of all non-retained state.
            P_OFF: begin
               result_q <= '0;
               op_a     <= '0;
               op_b     <= '0;
               op_q     <= '0;
               mul_cnt  <= '0;
               exec     <= IDLE;
               if (!pwr_req) begin
                  ack_q  <= 1'b0;
                  pstate <= P_RESTORE;
               end
            end
            P_RESTORE: begin
               result_q <= ret_q;
               iso_q    <= 1'b0;
               pstate   <= P_ON;
            end
            default: pstate <= P_ON;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_pm.sv
// Directed plus randomized bench for alu_pm against an arithmetic reference model.
module tb_alu_pm;

   localparam int               W       = 16;
   localparam int               MLAT    = 4;
   localparam logic [W-1:0]     ISO     = 16'hA5A5;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] A, B;
   logic [3:0]   opcode;
   logic         start, pwr_req;
   logic         ready, busy, result_valid, err, pwr_ack, iso_active;
   logic [W-1:0] result;

   int errors = 0;
   int checks = 0;

   alu_pm #(.WIDTH(W), .MUL_LAT(MLAT), .ISO_VAL(ISO)) dut (
      .clk          (clk),
      .rst          (rst),
      .A            (A),
      .B            (B),
      .opcode       (opcode),
      .start        (start),
      .ready        (ready),
      .busy         (busy),
      .result       (result),
      .result_valid (result_valid),
      .err          (err),
      .pwr_req      (pwr_req),
      .pwr_ack      (pwr_ack),
      .iso_active   (iso_active)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model computed directly from the operation definitions.
   function automatic int modelResult(input int op, input int a, input int b);
      int     sa;
      longint p;
      case (op)
         0: return (a + b) & 32'hFFFF;
         1: return (a - b + 65536) & 32'hFFFF;
         2: return a & b;
         3: return a | b;
         4: return a ^ b;
         5: return (~(a | b)) & 32'hFFFF;
         6: return (a << (b % 16)) & 32'hFFFF;
         7: begin
            sa = (a >= 32768) ? a - 65536 : a;
            return (sa >>> (b % 16)) & 32'hFFFF;
         end
         8: begin
            p = longint'(a) * longint'(b);
            return int'(p % 65536);
         end
         9:  return (b == 0) ? 65535 : a / b;
         10: return (b == 0) ? a : a % b;
         default: return 0;
      endcase
   endfunction

   function automatic int modelLatency(input int op, input int b);
      if (op == 8) return MLAT;
      if ((op == 9 || op == 10) && b != 0) return W + 1;
      return 1;
   endfunction

   function automatic int modelErr(input int op, input int b);
      return (op > 10 || ((op == 9 || op == 10) && b == 0)) ? 1 : 0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic st);
      opcode = op;
      A      = a;
      B      = b;
      start  = st;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
         else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
         end
   endtask

   task automatic waitReady(input string tag);
      int n = 0;
      while (!ready && n < 40) begin
         tick();
         n++;
      end
      if (!ready) checkOutput({tag, "_ready_timeout"}, 32'(ready), 32'd1);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_result"}, 32'(result), 32'h0);
      checkOutput({tag, "_valid"},  32'(result_valid), 32'h0);
      checkOutput({tag, "_busy"},   32'(busy), 32'h0);
      checkOutput({tag, "_err"},    32'(err), 32'h0);
      checkOutput({tag, "_ack"},    32'(pwr_ack), 32'h0);
      checkOutput({tag, "_iso"},    32'(iso_active), 32'h0);
   endtask

   // Issue one op and verify latency, result, err and busy against the model.
   task automatic runOp(input string tag, input logic [3:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b);
      int lat;
      bit seen;
      bit busyOk;
      waitReady(tag);
      applyStimulus(op, a, b, 1'b1);
      tick();
      applyStimulus(~op, ~a, ~b, 1'b0);
      lat    = 1;
      seen   = 0;
      busyOk = 1;
      while (lat <= 40 && !seen) begin
         if (result_valid) seen = 1;
         else begin
            if (!busy) busyOk = 0;
            tick();
            lat++;
         end
      end
      checkOutput({tag, "_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         checkOutput({tag, "_lat"},    32'(lat), 32'(modelLatency(int'(op), int'(b))));
         checkOutput({tag, "_result"}, 32'(result), 32'(modelResult(int'(op), int'(a), int'(b))));
         checkOutput({tag, "_err"},    32'(err), 32'(modelErr(int'(op), int'(b))));
         if (lat > 1) checkOutput({tag, "_busy"}, 32'(busyOk), 32'd1);
      end
   endtask

   initial begin
      int pulses;
      int n;
      logic [3:0] rop;
      logic [W-1:0] ra, rb;

      rst = 1'b1;
      pwr_req = 1'b0;
      applyStimulus(4'h0, '0, '0, 1'b0);
      tick();
      tick();
      checkResetOutputs("reset");
      checkOutput("reset_ready", 32'(ready), 32'd1);
      rst = 1'b0;
      tick();

      runOp("add_wrap", 4'h0, 16'hFFFF, 16'h0002);
      runOp("sra",      4'h7, 16'h8000, 16'h0003);
      runOp("mul",      4'h8, 16'h0100, 16'h0100);
      runOp("divu",     4'h9, 16'h0064, 16'h0007);
      runOp("remu",     4'hA, 16'h0064, 16'h0007);
      runOp("div0",     4'h9, 16'h1234, 16'h0000);
      runOp("rem0",     4'hA, 16'h1234, 16'h0000);
      runOp("illegal",  4'hC, 16'h1111, 16'h2222);

      // Power-down with retention; start while off must be ignored.
      runOp("pre_pwr", 4'h0, 16'h0055, 16'h0055);
      pwr_req = 1'b1;
      tick();
      checkOutput("save_iso",   32'(iso_active), 32'd0);
      checkOutput("save_ready", 32'(ready), 32'd0);
      tick();
      checkOutput("iso_iso",    32'(iso_active), 32'd1);
      checkOutput("iso_result", 32'(result), 32'(ISO));
      checkOutput("iso_ack",    32'(pwr_ack), 32'd0);
      tick();
      checkOutput("off_ack",    32'(pwr_ack), 32'd1);
      applyStimulus(4'h0, 16'h0001, 16'h0001, 1'b1);
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (result_valid) pulses++;
      end
      applyStimulus(4'h0, '0, '0, 1'b0);
      checkOutput("off_no_valid", 32'(pulses), 32'd0);
      checkOutput("off_result",   32'(result), 32'(ISO));
      checkOutput("off_ready",    32'(ready), 32'd0);
      checkOutput("off_ack_hold", 32'(pwr_ack), 32'd1);
      pwr_req = 1'b0;
      tick();
      checkOutput("restore_iso", 32'(iso_active), 32'd1);
      checkOutput("restore_ack", 32'(pwr_ack), 32'd0);
      tick();
      checkOutput("on_iso",    32'(iso_active), 32'd0);
      checkOutput("on_result", 32'(result), 32'h00AA);
      checkOutput("on_ready",  32'(ready), 32'd1);

      // Power request mid-divide: divide finishes first; drop req during save.
      applyStimulus(4'h9, 16'h0064, 16'h0007, 1'b1);
      tick();
      applyStimulus(4'h0, '0, '0, 1'b0);
      pwr_req = 1'b1;
      n = 1;
      while (!result_valid && n <= 40) begin
         tick();
         n++;
      end
      checkOutput("middiv_lat",    32'(n), 32'(W + 1));
      checkOutput("middiv_result", 32'(result), 32'h000E);
      checkOutput("middiv_iso",    32'(iso_active), 32'd0);
      tick();
      checkOutput("middiv_save_ready", 32'(ready), 32'd0);
      pwr_req = 1'b0;
      tick();
      checkOutput("middiv_iso2", 32'(iso_active), 32'd1);
      tick();
      checkOutput("middiv_off_ack", 32'(pwr_ack), 32'd1);
      tick();
      tick();
      checkOutput("middiv_on_result", 32'(result), 32'h000E);
      checkOutput("middiv_on_ready",  32'(ready), 32'd1);

      // start and pwr_req in the same idle cycle: no accept.
      applyStimulus(4'h0, 16'h0001, 16'h0001, 1'b1);
      pwr_req = 1'b1;
      tick();
      applyStimulus(4'h0, '0, '0, 1'b0);
      checkOutput("race_valid", 32'(result_valid), 32'd0);
      tick();
      tick();
      checkOutput("race_ack", 32'(pwr_ack), 32'd1);
      pwr_req = 1'b0;
      tick();
      tick();
      checkOutput("race_result", 32'(result), 32'h000E);

      // Reset in the middle of a divide discards it.
      applyStimulus(4'h9, 16'hFFFF, 16'h0003, 1'b1);
      tick();
      applyStimulus(4'h0, '0, '0, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      tick();
      checkResetOutputs("rst_div");
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (result_valid) pulses++;
      end
      checkOutput("rst_div_no_valid", 32'(pulses), 32'd0);

      // Reset while off.
      runOp("pre_off", 4'h3, 16'h0F00, 16'h00F0);
      pwr_req = 1'b1;
      tick();
      tick();
      tick();
      checkOutput("rst_off_ack_before", 32'(pwr_ack), 32'd1);
      rst = 1'b1;
      pwr_req = 1'b0;
      tick();
      checkResetOutputs("rst_off");
      rst = 1'b0;
      tick();
      checkOutput("rst_off_ready", 32'(ready), 32'd1);

      // Randomized ops, issued back to back.
      for (int i = 0; i < 40; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = 16'($urandom);
         rb  = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
         runOp($sformatf("rand%0d_op%0h", i, rop), rop, ra, rb);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
